// File: rtl/relu_pkg.sv
// Shared constants and types for the ReLU activation/backward path.
package relu_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int DEPTH_DEF      = 64;
  localparam int LEAK_SHIFT_DEF = 3;

  typedef logic signed [DATA_W_DEF-1:0] act_t;
  typedef logic signed [DATA_W_DEF-1:0] grad_t;

endpackage

// File: rtl/relu_mask_fifo.sv
// 1-bit-wide mask FIFO. The count is the only source of full/empty;
// pointers wrap naturally because DEPTH is a power of two.
module relu_mask_fifo
  import relu_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          wr_bit,
  input  logic          pop,
  output logic          rd_bit,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Next-state: flush wins over push/pop; stored bits are left as-is on flush.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_bit;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_bit = mem_q[rd_ptr_q];
  assign count  = count_q;

endmodule

// File: rtl/relu_backward_mask.sv
// ReLU backward gating: forward activations record a positivity bit, backward
// gradients are gated by the oldest recorded bit.
// Optional build macro RELU_BWD_LEAKY_EN: mask=0 gradients are scaled by
// 2^-LEAK_SHIFT (arithmetic shift) instead of being zeroed.
module relu_backward_mask
  import relu_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int LEAK_SHIFT = LEAK_SHIFT_DEF,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              fwd_valid,
  output logic              fwd_ready,
  input  logic [DATA_W-1:0] fwd_data,
  input  logic              bwd_valid,
  output logic              bwd_ready,
  input  logic [DATA_W-1:0] bwd_grad,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_grad,
  output logic [CW-1:0]     mask_count
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic              live_q, live_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_grad_q, out_grad_d;
  logic              mask_bit, rd_bit, push, pop;
  logic [CW-1:0]     count;
  logic [DATA_W-1:0] gated;

  // Strictly positive: sign clear and non-zero (derivative at 0 is 0).
  assign mask_bit = !fwd_data[DATA_W-1] && (fwd_data != '0);

  // live_q keeps fwd_ready low while reset is held.
  assign live_d    = 1'b1;
  assign fwd_ready = live_q && (count != FULL_COUNT) && !flush;
  assign bwd_ready = (count != '0) && (!out_valid_q || out_ready) && !flush;
  assign push      = fwd_valid && fwd_ready;
  assign pop       = bwd_valid && bwd_ready;

  relu_mask_fifo #(.DEPTH(DEPTH)) u_mask_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .push   (push),
    .wr_bit (mask_bit),
    .pop    (pop),
    .rd_bit (rd_bit),
    .count  (count)
  );

`ifdef RELU_BWD_LEAKY_EN
  logic signed [DATA_W-1:0] grad_s;
  assign grad_s = bwd_grad;
`endif

  // Gradient gate: pass on mask=1, otherwise zero (or leaky-scaled).
  always_comb begin
    gated = bwd_grad;
    if (!rd_bit) begin
`ifdef RELU_BWD_LEAKY_EN
      gated = grad_s >>> LEAK_SHIFT;
`else
      gated = '0;
`endif
    end
  end

  // Output register: a pop replaces contents even while being accepted.
  always_comb begin
    out_valid_d = out_valid_q;
    out_grad_d  = out_grad_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (pop) begin
      out_valid_d = 1'b1;
      out_grad_d  = gated;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_grad_q  <= '0;
    end else begin
      live_q      <= live_d;
      out_valid_q <= out_valid_d;
      out_grad_q  <= out_grad_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_grad   = out_grad_q;
  assign mask_count = count;

endmodule

// File: tb/tb_relu_backward_mask.sv
// Bench for relu_backward_mask: directed steps followed by random traffic,
// checked against a queue-based reference model.
module tb_relu_backward_mask;

  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int LS    = 3;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          fwd_valid;
  logic          fwd_ready;
  logic [DW-1:0] fwd_data;
  logic          bwd_valid;
  logic          bwd_ready;
  logic [DW-1:0] bwd_grad;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_grad;
  logic [6:0]    mask_count;

  relu_backward_mask #(.DATA_W(DW), .DEPTH(DEPTH), .LEAK_SHIFT(LS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .fwd_valid  (fwd_valid),
    .fwd_ready  (fwd_ready),
    .fwd_data   (fwd_data),
    .bwd_valid  (bwd_valid),
    .bwd_ready  (bwd_ready),
    .bwd_grad   (bwd_grad),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_grad   (out_grad),
    .mask_count (mask_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  bit          mq[$];
  bit          m_ov;
  logic [15:0] m_og;
  bit          m_live;

  function automatic logic [15:0] ref_gate(bit m, logic [15:0] g);
    int gi;
    int q;
    if (m) return g;
`ifdef RELU_BWD_LEAKY_EN
    gi = int'($signed(g));
    q  = gi / (1 << LS);
    if ((gi % (1 << LS) != 0) && (gi < 0)) q = q - 1;
    return 16'(q);
`else
    gi = 0;
    q  = gi;
    return 16'(q);
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check readies, advance model at the edge, check outputs.
  task automatic step();
    bit efr, ebr, pu, po, b;
    #1;
    efr = m_live && (mq.size() != DEPTH) && !flush;
    ebr = (mq.size() != 0) && (!m_ov || out_ready) && !flush;
    chk("fwd_ready", {31'd0, fwd_ready}, {31'd0, efr});
    chk("bwd_ready", {31'd0, bwd_ready}, {31'd0, ebr});
    pu = fwd_valid && efr;
    po = bwd_valid && ebr;
    @(posedge clk);
    if (flush) begin
      mq.delete();
      m_ov = 1'b0;
    end else begin
      if (po) begin
        b    = mq.pop_front();
        m_og = ref_gate(b, bwd_grad);
        m_ov = 1'b1;
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (pu) mq.push_back(int'($signed(fwd_data)) > 0);
    end
    m_live = 1'b1;
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("out_grad", {16'd0, out_grad}, {16'd0, m_og});
    chk("mask_count", {25'd0, mask_count}, mq.size());
    @(negedge clk);
  endtask

  task automatic drv(bit fv, logic [15:0] fd, bit bv, logic [15:0] bg, bit ordy, bit fl);
    fwd_valid = fv;
    fwd_data  = fd;
    bwd_valid = bv;
    bwd_grad  = bg;
    out_ready = ordy;
    flush     = fl;
    step();
  endtask

  function automatic logic [15:0] rand_act();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  logic [15:0] exp2[3];
  logic [15:0] exp_leak;
  logic [15:0] held;

  initial begin
`ifdef RELU_BWD_LEAKY_EN
    exp2[0] = 16'h0020; exp2[1] = 16'h0020; exp2[2] = 16'h0100;
    exp_leak = 16'hFFE0;
`else
    exp2[0] = 16'h0000; exp2[1] = 16'h0000; exp2[2] = 16'h0100;
    exp_leak = 16'h0000;
`endif
    rst_n = 1'b0;
    flush = 1'b0; fwd_valid = 1'b0; fwd_data = '0;
    bwd_valid = 1'b0; bwd_grad = '0; out_ready = 1'b0;
    m_ov = 1'b0; m_og = '0; m_live = 1'b0;

    // Reset values while reset is held.
    #12;
    chk("rst_fwd_ready", {31'd0, fwd_ready}, 0);
    chk("rst_bwd_ready", {31'd0, bwd_ready}, 0);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_out_grad", {16'd0, out_grad}, 0);
    chk("rst_count", {25'd0, mask_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drv(0, 0, 0, 0, 1, 0);
    drv(0, 0, 0, 0, 1, 0);
    chk("post_rst_fwd_ready", {31'd0, fwd_ready}, 1);

    // Single positive activation passes its gradient.
    drv(1, 16'h0010, 0, 0, 1, 0);
    chk("t1_count1", {25'd0, mask_count}, 1);
    drv(0, 0, 1, 16'h0100, 1, 0);
    chk("t1_grad", {16'd0, out_grad}, 16'h0100);
    chk("t1_count0", {25'd0, mask_count}, 0);
    drv(0, 0, 0, 0, 1, 0);

    // Negative, zero, positive activations in order.
    drv(1, 16'hFFF0, 0, 0, 1, 0);
    drv(1, 16'h0000, 0, 0, 1, 0);
    drv(1, 16'h7FFF, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 1, 16'h0100, 1, 0);
      chk("t2_out", {16'd0, out_grad}, {16'd0, exp2[i]});
    end
    drv(1, 16'h0000, 0, 0, 1, 0);
    drv(0, 0, 1, 16'hFF00, 1, 0);
    chk("t2_leak", {16'd0, out_grad}, {16'd0, exp_leak});
    drv(0, 0, 0, 0, 1, 0);

    // Fill to DEPTH; push refused while full even with a concurrent pop.
    for (int i = 0; i < DEPTH; i++) drv(1, rand_act(), 0, 0, 1, 0);
    chk("t3_full_count", {25'd0, mask_count}, DEPTH);
    chk("t3_full_ready", {31'd0, fwd_ready}, 0);
    drv(1, 16'h0005, 1, 16'($urandom), 1, 0);
    chk("t3_pushpop_full", {25'd0, mask_count}, DEPTH - 1);
    for (int i = 0; i < 400 && mq.size() != 0; i++)
      drv(0, 0, 1, 16'($urandom), 1'($urandom_range(0, 1)), 0);
    drv(0, 0, 0, 0, 1, 0);
    chk("t3_drained", {25'd0, mask_count}, 0);

    // Backpressure holds the output; release gives one pop per cycle.
    for (int i = 0; i < 5; i++) drv(1, rand_act(), 0, 0, 1, 0);
    drv(0, 0, 1, 16'($urandom), 0, 0);
    held = out_grad;
    for (int i = 0; i < 3; i++) begin
      drv(0, 0, 1, 16'($urandom), 0, 0);
      chk("t4_hold", {16'd0, out_grad}, {16'd0, held});
      chk("t4_bready", {31'd0, bwd_ready}, 0);
    end
    for (int i = 0; i < 4; i++) begin
      drv(0, 0, 1, 16'($urandom), 1, 0);
      chk("t4_b2b", {25'd0, mask_count}, 3 - i);
    end
    drv(0, 0, 0, 0, 1, 0);

    // Empty: no pop; a push becomes poppable on the next cycle.
    drv(0, 0, 1, 16'h1234, 1, 0);
    drv(0, 0, 1, 16'h1234, 1, 0);
    chk("t5_empty_valid", {31'd0, out_valid}, 0);
    drv(1, 16'h0003, 1, 16'h1234, 1, 0);
    chk("t5_no_bypass", {31'd0, out_valid}, 0);
    drv(0, 0, 1, 16'h1234, 1, 0);
    chk("t5_pop_valid", {31'd0, out_valid}, 1);
    chk("t5_pop_grad", {16'd0, out_grad}, 16'h1234);
    drv(0, 0, 0, 0, 1, 0);

    // Flush with 10 stored and output valid.
    for (int i = 0; i < 11; i++) drv(1, rand_act(), 0, 0, 1, 0);
    drv(0, 0, 1, 16'($urandom), 0, 0);
    chk("t6_pre_count", {25'd0, mask_count}, 10);
    drv(1, rand_act(), 1, 16'($urandom), 1, 1);
    chk("t6_flush_count", {25'd0, mask_count}, 0);
    chk("t6_flush_valid", {31'd0, out_valid}, 0);
    drv(1, 16'h0010, 0, 0, 1, 0);
    drv(0, 0, 1, 16'h0100, 1, 0);
    chk("t6_after_flush", {16'd0, out_grad}, 16'h0100);
    drv(0, 0, 0, 0, 1, 0);

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 11; i++) drv(1, rand_act(), 0, 0, 1, 0);
    drv(0, 0, 1, 16'h4321, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_rst_count", {25'd0, mask_count}, 0);
    chk("t7_rst_valid", {31'd0, out_valid}, 0);
    chk("t7_rst_grad", {16'd0, out_grad}, 0);
    chk("t7_rst_fwd_ready", {31'd0, fwd_ready}, 0);
    mq.delete(); m_ov = 1'b0; m_og = '0; m_live = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drv(0, 0, 0, 0, 1, 0);
    drv(1, 16'h0010, 0, 0, 1, 0);
    drv(0, 0, 1, 16'h0100, 1, 0);
    chk("t7_after_rst", {16'd0, out_grad}, 16'h0100);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      drv(1'($urandom_range(0, 1)), rand_act(),
          1'($urandom_range(0, 1)), 16'($urandom),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/relu_backward_mask.md
# relu_backward_mask

Backward-pass counterpart of the pipelined ReLU stage in the activation path. During the forward pass, each activation's positivity bit is captured into an internal mask FIFO. During the backward pass, each upstream gradient is gated by the oldest stored mask bit in FIFO order: passed through if the activation was > 0, zeroed otherwise. The block sits between the backward gradient stream and the SIMD dot-product weight-update path.

## Interface
Parameters:
- DATA_W, 16: activation and gradient width, two's complement.
- DEPTH, 64: mask FIFO entries; power of two, ≥ 2.
- LEAK_SHIFT, 3: negative-slope shift; used only when RELU_BWD_LEAKY_EN is defined.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of the FIFO and output register.
- fwd_valid  in  1  forward activation valid.
- fwd_ready  out  1  high when the mask FIFO can accept an entry.
- fwd_data  in  DATA_W  forward activation (ReLU input).
- bwd_valid  in  1  upstream gradient valid.
- bwd_ready  out  1  gradient accepted on this cycle if bwd_valid is also high.
- bwd_grad  in  DATA_W  upstream gradient dL/dy.
- out_valid  out  1  gated gradient valid.
- out_ready  in  1  downstream ready.
- out_grad  out  DATA_W  gated gradient dL/dx.
- mask_count  out  $clog2(DEPTH)+1  number of stored mask bits.

## Operation
- Mask bit = 1 iff fwd_data is signed > 0. Zero gives 0, matching the convention that the ReLU derivative at 0 is 0.
- Push: occurs when fwd_valid && fwd_ready. fwd_ready = (mask_count != DEPTH) && !flush.
- Pop: occurs when bwd_valid && bwd_ready. bwd_ready = (mask_count != 0) && (!out_valid || out_ready) && !flush.
- On pop, the output register loads: out_grad = mask ? bwd_grad : 0, and out_valid is set.
- Output register: out_valid is cleared when out_valid && out_ready and no new pop occurs. A pop on the same cycle as a downstream accept replaces the register contents, giving full throughput.
- Push and pop in the same cycle: mask_count is unchanged, and both pointers advance.
- Full: a push is refused even if a pop happens in the same cycle (fwd_ready depends only on the registered count).
- Empty: bwd_ready is low. The mask FIFO has no bypass, so a gradient cannot consume a mask bit that is being pushed in the same cycle.
- Pointers wrap modulo DEPTH. mask_count is the source of truth for full and empty.
- flush (priority over push and pop): pointers go to 0, mask_count goes to 0, out_valid goes to 0. out_grad holds its value.
- Reset values: fwd_ready=0 while rst_n is low and 1 after reset; bwd_ready=0; out_valid=0; out_grad=0; mask_count=0.

## Timing
- A pushed mask bit becomes visible on the cycle after the push: mask_count increments at the edge, and bwd_ready can assert in the following cycle.
- Gradient latency: 1 cycle. A pop at edge N presents out_valid and out_grad after edge N.
- While out_valid && !out_ready: out_grad is held stable and bwd_ready=0.
- Reset asserted mid-operation: all state clears asynchronously. Mask bits already stored are lost.

## Configuration
- RELU_BWD_LEAKY_EN defined: the mask=0 path outputs bwd_grad >>> LEAK_SHIFT (arithmetic shift, sign-extended, truncating toward −∞). This is the leaky-ReLU derivative.
- RELU_BWD_LEAKY_EN undefined: the mask=0 path outputs 0. LEAK_SHIFT is ignored.

## Structure
- Shared package relu_pkg holds:
  - DATA_W default constant;
  - typedef act_t (signed [DATA_W-1:0]);
  - typedef grad_t;
  - the LEAK_SHIFT default.
- Sub-module relu_mask_fifo: a 1-bit-wide, DEPTH-entry synchronous FIFO with push, pop, flush, count, and rd_bit.
- The top level contains the mask comparator, the gating/leak mux, and the output register and handshake.

## Test plan
- Reset, then push fwd 0x0010 and present grad 0x0100 → out_grad=0x0100 one cycle after the pop; mask_count goes 1→0.
- Push 0xFFF0, then 0x0000, then 0x7FFF; present grads 0x0100 ×3 → outputs 0x0000, 0x0000, 0x0100 in order. With RELU_BWD_LEAKY_EN and LEAK_SHIFT=3: 0x0020, 0x0020, 0x0100. Grad 0xFF00 on a zero mask → 0xFFE0.
- Push 64 entries with no pops → mask_count=64 and fwd_ready=0. A push and pop in the same cycle while full → count=63, and the push is not accepted.
- Hold out_ready=0 with bwd_valid=1 → out_grad stays stable and bwd_ready=0. Release out_ready → back-to-back pops, one per cycle.
- Present bwd_valid=1 while empty → bwd_ready=0 and out_valid stays 0. Push once → the pop occurs on the next cycle.
- With 10 entries stored and out_valid=1, assert flush (or drop rst_n asynchronously) → mask_count=0 and out_valid=0. A subsequent push and pop behaves as it does after reset.
